// File: rtl/spi_note_master.sv
// Transmit-only SPI master: serialises one 32-bit note frame per request, MSB first.
// One-deep holding buffer lets the next frame queue while the current one shifts.
module spi_note_master #(
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] note1,
   input  logic [7:0] note2,
   input  logic [7:0] note3,
   input  logic [1:0] notescount,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       sck,
   output logic       sdi
);
   // state  | meaning
   // IDLE   | waiting for a held frame
   // LOW    | sck low half-period
   // HIGH   | sck high half-period, shift on exit
   // GAP    | sck held low between frames
   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   state_t        r_state, w_state_n;
   logic [DW-1:0] r_div, w_div_n;
   logic [GW-1:0] r_gap, w_gap_n;
   logic [4:0]    r_bitcnt, w_bitcnt_n;
   logic [31:0]   r_shreg, w_shreg_n;
   logic [31:0]   r_hold, w_hold_n;
   logic          r_hold_valid, w_hold_valid_n;
   logic          r_sck, w_sck_n;
   logic          r_sdi, w_sdi_n;
   logic          r_done, w_done_n;
   logic          r_busy, r_ready;
   logic          w_accept, w_take, w_div_last;
   logic [31:0]   w_frame;

   assign w_frame    = {6'b0, notescount, note3, note2, note1};
   assign w_accept   = load & r_ready;
   assign w_div_last = (r_div == DW'(CLK_DIV - 1));

   always_comb begin
      w_state_n  = r_state;
      w_div_n    = r_div;
      w_gap_n    = r_gap;
      w_bitcnt_n = r_bitcnt;
      w_shreg_n  = r_shreg;
      w_sck_n    = r_sck;
      w_sdi_n    = r_sdi;
      w_done_n   = 1'b0;
      w_take     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_hold_valid) begin
               w_take     = 1'b1;
               w_shreg_n  = r_hold;
               w_sdi_n    = r_hold[31];
               w_bitcnt_n = 5'd0;
               w_div_n    = '0;
               w_state_n  = S_LOW;
            end
         end
         S_LOW: begin
            if (w_div_last) begin
               w_sck_n   = 1'b1;
               w_div_n   = '0;
               w_state_n = S_HIGH;
            end else begin
               w_div_n = r_div + 1'b1;
            end
         end
         S_HIGH: begin
            if (w_div_last) begin
               w_sck_n = 1'b0;
               w_div_n = '0;
               if (r_bitcnt == 5'd31) begin
                  w_sdi_n   = 1'b0;
                  w_gap_n   = '0;
                  w_state_n = S_GAP;
               end else begin
                  w_shreg_n  = {r_shreg[30:0], 1'b0};
                  w_sdi_n    = r_shreg[30];
                  w_bitcnt_n = r_bitcnt + 5'd1;
                  w_state_n  = S_LOW;
               end
            end else begin
               w_div_n = r_div + 1'b1;
            end
         end
         S_GAP: begin
            if (r_gap == GW'(GAP_CYC - 1)) begin
               w_done_n  = 1'b1;
               w_state_n = S_IDLE;
            end else begin
               w_gap_n = r_gap + 1'b1;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
      // A new accept wins over the engine emptying hold in the same cycle.
      w_hold_n       = w_accept ? w_frame : r_hold;
      w_hold_valid_n = w_accept ? 1'b1 : (w_take ? 1'b0 : r_hold_valid);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_div        <= '0;
         r_gap        <= '0;
         r_bitcnt     <= 5'd0;
         r_shreg      <= 32'd0;
         r_hold       <= 32'd0;
         r_hold_valid <= 1'b0;
         r_sck        <= 1'b0;
         r_sdi        <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_ready      <= 1'b1;
      end else begin
         r_state      <= w_state_n;
         r_div        <= w_div_n;
         r_gap        <= w_gap_n;
         r_bitcnt     <= w_bitcnt_n;
         r_shreg      <= w_shreg_n;
         r_hold       <= w_hold_n;
         r_hold_valid <= w_hold_valid_n;
         r_sck        <= w_sck_n;
         r_sdi        <= w_sdi_n;
         r_done       <= w_done_n;
         r_busy       <= (w_state_n != S_IDLE);
         r_ready      <= ~w_hold_valid_n;
      end
   end

   assign ready = r_ready;
   assign busy  = r_busy;
   assign done  = r_done;
   assign sck   = r_sck;
   assign sdi   = r_sdi;
endmodule
